// File: rtl/sec32_check_gen_if.sv
// sec32_check_gen_if: upstream data stream and downstream codeword stream of the SEC check generator.
// master drives words in and takes codewords out; slave is the generator itself.
interface sec32_check_gen_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_corr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] God;
    logic [7:0]  Goc;
    logic        Gr;

    modport master (
        output in_valid, in_data, in_corr, out_ready,
        input  in_ready, out_valid, God, Goc, Gr
    );

    modport slave (
        input  in_valid, in_data, in_corr, out_ready,
        output in_ready, out_valid, God, Goc, Gr
    );
endinterface

// File: rtl/sec32_check_gen.sv
// sec32_check_gen: 32-bit SEC encoder feeding a 2-entry skid buffer; optional one-shot
// single-bit error injection when SEC_ERR_INJECT_EN is defined.
module sec32_check_gen #(
    parameter int CNT_W = 16
) (
    input  logic             Gclk,
    input  logic             Grst_n,
    sec32_check_gen_if.slave bus,
    output logic [CNT_W-1:0] word_cnt
`ifdef SEC_ERR_INJECT_EN
    ,
    input  logic             inj_arm,
    input  logic [5:0]       inj_bit
`endif
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t             state_q, state_d;
    logic [40:0]        a_q, a_d, b_q, b_d;
    logic               in_ready_q, in_ready_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [39:0]        flip;
    logic [40:0]        new_entry;
    logic               in_xfer, out_xfer;

    // Entry layout {corr, check[7:0], data[31:0]}; codeword bit i maps to entry bit i.
    function automatic logic [7:0] gen_check(input logic [31:0] d);
        return {^(d & 32'h8888F0F0), ^(d & 32'h44440F0F), ^(d & 32'h2222FF00), ^(d & 32'h111100FF),
                ^(d & 32'hF0F08888), ^(d & 32'h0F0F4444), ^(d & 32'hFF002222), ^(d & 32'h00FF1111)};
    endfunction

    assign in_xfer   = bus.in_valid & in_ready_q;
    assign out_xfer  = (state_q != EMPTY) & bus.out_ready;
    assign new_entry = {bus.in_corr, {gen_check(bus.in_data), bus.in_data} ^ flip};

`ifdef SEC_ERR_INJECT_EN
    logic arm_q, arm_d, arm_eff;

    // Arming in the same cycle as a transfer applies to that word.
    assign arm_eff = arm_q | inj_arm;
    assign flip    = (arm_eff && inj_bit < 6'd40) ? 40'd1 << inj_bit : '0;

    always_comb arm_d = in_xfer ? 1'b0 : arm_eff;

    always_ff @(posedge Gclk or negedge Grst_n) begin
        if (!Grst_n) arm_q <= 1'b0;
        else         arm_q <= arm_d;
    end
`else
    assign flip = '0;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    a_d     = new_entry;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    a_d = new_entry;
                end else if (in_xfer) begin
                    b_d     = new_entry;
                    state_d = TWO;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_xfer) begin
                    a_d     = b_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        in_ready_d = (state_d != TWO);
        cnt_d      = cnt_q + CNT_W'(in_xfer);
    end

    always_ff @(posedge Gclk or negedge Grst_n) begin
        if (!Grst_n) begin
            state_q    <= EMPTY;
            a_q        <= '0;
            b_q        <= '0;
            in_ready_q <= 1'b1;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            in_ready_q <= in_ready_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.God       = a_q[31:0];
    assign bus.Goc       = a_q[39:32];
    assign bus.Gr        = a_q[40];
    assign word_cnt      = cnt_q;
endmodule

// File: tb/tb_sec32_check_gen.sv
// tb_sec32_check_gen: directed checks of the SEC check generator, its skid buffer and counter;
// injection steps run only when SEC_ERR_INJECT_EN is defined.
module tb_sec32_check_gen;
    logic Gclk = 1'b0;
    logic Grst_n = 1'b0;
    always #5 Gclk = ~Gclk;

    sec32_check_gen_if bus ();
    sec32_check_gen_if sbus ();
    logic [15:0] word_cnt;
    logic [3:0]  s_cnt;
`ifdef SEC_ERR_INJECT_EN
    logic        inj_arm;
    logic [5:0]  inj_bit;
`endif

    sec32_check_gen u_dut (
        .Gclk     (Gclk),
        .Grst_n   (Grst_n),
        .bus      (bus),
        .word_cnt (word_cnt)
`ifdef SEC_ERR_INJECT_EN
        ,
        .inj_arm  (inj_arm),
        .inj_bit  (inj_bit)
`endif
    );

    sec32_check_gen #(.CNT_W(4)) u_small (
        .Gclk     (Gclk),
        .Grst_n   (Grst_n),
        .bus      (sbus),
        .word_cnt (s_cnt)
`ifdef SEC_ERR_INJECT_EN
        ,
        .inj_arm  (1'b0),
        .inj_bit  (6'd0)
`endif
    );

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Membership written from the bit lists, independent of any mask constants.
    function automatic logic [7:0] ref_chk(input logic [31:0] d);
        logic [7:0] c = '0;
        for (int i = 0; i < 32; i++) begin
            if (d[i]) begin
                c[0] = c[0] ^ ((i < 16 && i % 4 == 0) || (i >= 16 && i < 24));
                c[1] = c[1] ^ ((i < 16 && i % 4 == 1) || i >= 24);
                c[2] = c[2] ^ ((i < 16 && i % 4 == 2) || (i >= 16 && i < 20) || (i >= 24 && i < 28));
                c[3] = c[3] ^ ((i < 16 && i % 4 == 3) || (i >= 20 && i < 24) || i >= 28);
                c[4] = c[4] ^ (i < 8 || (i >= 16 && i % 4 == 0));
                c[5] = c[5] ^ ((i >= 8 && i < 16) || (i >= 16 && i % 4 == 1));
                c[6] = c[6] ^ ((i < 16 && (i / 4) % 2 == 0) || (i >= 16 && i % 4 == 2));
                c[7] = c[7] ^ ((i < 16 && (i / 4) % 2 == 1) || (i >= 16 && i % 4 == 3));
            end
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge Gclk);
        #1;
    endtask

    task automatic do_reset();
        Grst_n = 1'b0;
        repeat (2) @(posedge Gclk);
        #1;
        Grst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] q[$];
        logic [31:0] wd, ex;
        int sent, got;
        bus.in_valid = 0; bus.in_data = 0; bus.in_corr = 0; bus.out_ready = 0;
        sbus.in_valid = 0; sbus.in_data = 0; sbus.in_corr = 0; sbus.out_ready = 1;
`ifdef SEC_ERR_INJECT_EN
        inj_arm = 0; inj_bit = 0;
`endif
        do_reset();
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_God", bus.God, 0);
        check("rst_Goc", bus.Goc, 0);
        check("rst_Gr", bus.Gr, 0);
        check("rst_word_cnt", word_cnt, 0);

        bus.in_valid = 1; bus.in_data = 32'h0; bus.in_corr = 1; bus.out_ready = 1;
        tick();
        check("zero_God", bus.God, 0);
        check("zero_Goc", bus.Goc, 8'h00);
        check("zero_Gr", bus.Gr, 1);
        check("zero_out_valid", bus.out_valid, 1);
        bus.in_data = 32'h0000_0001; bus.in_corr = 0;
        tick();
        check("d1_God", bus.God, 32'h0000_0001);
        check("d1_Goc", bus.Goc, 8'h51);
        check("d1_Gr", bus.Gr, 0);
        bus.in_data = 32'h8000_0000; bus.in_corr = 1;
        tick();
        check("d31_Goc", bus.Goc, 8'h8A);
        bus.in_data = 32'hFFFF_FFFF;
        tick();
        check("ones_God", bus.God, 32'hFFFF_FFFF);
        check("ones_Goc", bus.Goc, 8'h00);
        bus.in_valid = 0;
        tick();
        check("drain_out_valid", bus.out_valid, 0);
        check("cnt_after_4", word_cnt, 4);

        bus.out_ready = 0; bus.in_valid = 1; bus.in_data = 32'hA1A1_0001; bus.in_corr = 0;
        tick();
        check("bp_A1_God", bus.God, 32'hA1A1_0001);
        check("bp_A1_Goc", bus.Goc, ref_chk(32'hA1A1_0001));
        check("bp_ready_after_1", bus.in_ready, 1);
        bus.in_data = 32'hA2A2_0002; bus.in_corr = 1;
        tick();
        check("bp_ready_after_2", bus.in_ready, 0);
        check("bp_A1_hold", bus.God, 32'hA1A1_0001);
        bus.in_data = 32'hA3A3_0003; bus.in_corr = 0;
        tick();
        check("bp_A3_blocked", bus.in_ready, 0);
        check("bp_A1_hold2", bus.God, 32'hA1A1_0001);
        check("bp_cnt", word_cnt, 6);
        bus.out_ready = 1;
        tick();
        check("bp_A2_out", bus.God, 32'hA2A2_0002);
        check("bp_A2_Gr", bus.Gr, 1);
        check("bp_ready_back", bus.in_ready, 1);
        tick();
        check("bp_A3_out", bus.God, 32'hA3A3_0003);
        check("bp_A3_Goc", bus.Goc, ref_chk(32'hA3A3_0003));
        bus.in_valid = 0;
        tick();
        check("bp_empty", bus.out_valid, 0);
        check("bp_cnt_final", word_cnt, 7);

        do_reset();
        sent = 0; got = 0; wd = $urandom;
        for (int cyc = 0; cyc < 4000 && got < 256; cyc++) begin
            bus.in_valid = (sent < 256); bus.in_data = wd; bus.in_corr = wd[3];
            bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge Gclk);
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) check("stream_spurious", bus.out_valid, 0);
                else begin
                    ex = q.pop_front();
                    check("stream_word", {bus.God, bus.Goc, bus.Gr}, {ex, ref_chk(ex), ex[3]});
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(wd);
                sent++;
                wd = $urandom;
            end
            @(posedge Gclk);
            #1;
        end
        bus.in_valid = 0;
        check("stream_count", got, 256);
        check("stream_word_cnt", word_cnt, 16'h0100);

        sbus.in_valid = 1;
        repeat (16) tick();
        check("small_wrap", s_cnt, 0);
        tick();
        check("small_cnt_17", s_cnt, 1);
        sbus.in_valid = 0;

        bus.out_ready = 0; bus.in_valid = 1; bus.in_data = 32'h1234_5678;
        tick();
        bus.in_data = 32'h9ABC_DEF0;
        tick();
        bus.in_valid = 0;
        check("full_in_ready", bus.in_ready, 0);
        #2 Grst_n = 0;
        #1;
        check("async_out_valid", bus.out_valid, 0);
        check("async_word_cnt", word_cnt, 0);
        check("async_in_ready", bus.in_ready, 1);
        check("async_God", bus.God, 0);
        check("async_small_cnt", s_cnt, 0);
        @(posedge Gclk);
        #1 Grst_n = 1;
        bus.out_ready = 1;
        tick();
        check("post_rst_discard", bus.out_valid, 0);

`ifdef SEC_ERR_INJECT_EN
        bus.in_valid = 1; bus.in_data = 0; bus.in_corr = 1; inj_bit = 6'd5; inj_arm = 1;
        tick();
        inj_arm = 0;
        check("inj5_God", bus.God, 32'h20);
        check("inj5_Goc", bus.Goc, 8'h00);
        check("inj5_syndrome", ref_chk(bus.God) ^ bus.Goc, 8'h92);
        tick();
        check("inj_oneshot", bus.God, 0);
        bus.in_valid = 0; inj_bit = 6'd33; inj_arm = 1;
        tick();
        inj_arm = 0; bus.in_valid = 1;
        tick();
        check("inj33_Goc", bus.Goc, 8'h02);
        check("inj33_God", bus.God, 0);
        bus.in_valid = 0; inj_bit = 6'd45; inj_arm = 1;
        tick();
        inj_arm = 0; bus.in_valid = 1;
        tick();
        check("inj45_clean", {bus.God, bus.Goc}, 0);
        bus.in_valid = 0;
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
